// File: rtl/dally_corner_router_pkg.sv
// Shared types and header-field helpers for the mesh corner router.
package router_pkg;

   typedef enum logic [1:0] {CORNERSW, EDGESW, CENTERSW} router_type_e;
   typedef enum logic [1:0] {R_PROC = 2'd0, R_X = 2'd1, R_Y = 2'd2, R_XY = 2'd3} route_e;

   localparam int unsigned NPORTS = 4;

   // Width of one coordinate field for coordinates 0..maxc (never narrower than 1 bit)
   function automatic int unsigned field_w(input int unsigned maxc);
      int unsigned w;
      w = $clog2(maxc + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Output selection from the X/Y "differs" bits; index order proc, port1, port2, port3
   function automatic route_e route_of(input router_type_e rt, input logic dx, input logic dy);
      route_e r;
      unique case (rt)
         CORNERSW: r = route_e'({dy, dx});
         default:  r = route_e'({dy, dx}); // edge/centre switches share the corner decode
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dally_corner_router_if.sv
// Two-phase (transition) req/ack link carrying one flit.
interface RTPort #(parameter int unsigned N = 32);
   logic         req;
   logic         ack;
   logic [N-1:0] data;

   modport Input  (input req, input data, output ack);
   modport Output (output req, output data, input ack);
endinterface

// File: rtl/dally_corner_router_rr_arbiter4.sv
// Four-way round-robin arbiter; pointer moves past the winner when en_i is high.
module rr_arbiter4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_i,
   input  logic       en_i,
   output logic [3:0] gnt_c_o
);

   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx;
   logic       found;

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 2'd0;
      else     ptr_q <= ptr_d;
   end

   // Search from the pointer upwards, wrapping, for the first requester
   always_comb begin
      gnt_c_o = 4'd0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = 2'd0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            gnt_c_o[idx] = 1'b1;
            if (en_i) ptr_d = idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/dally_corner_router.sv
// Corner switch: four 2-phase input links, one-flit slot each, XY-difference routing,
// per-output round-robin arbitration onto four 2-phase output links.
module dally_corner_router
   import router_pkg::*;
#(
   parameter router_type_e rtype = CORNERSW,
   parameter int unsigned  n     = 32,
   parameter int unsigned  srcx  = 0,
   parameter int unsigned  srcy  = 0,
   parameter int unsigned  maxx  = 1,
   parameter int unsigned  maxy  = 1
) (
   input logic   clk,
   input logic   rst,
   RTPort.Input  proc_input,
   RTPort.Output proc_output,
   RTPort.Input  port1_input,
   RTPort.Output port1_output,
   RTPort.Input  port2_input,
   RTPort.Output port2_output,
   RTPort.Input  port3_input,
   RTPort.Output port3_output
);

   localparam int unsigned XW = field_w(maxx);
   localparam int unsigned YW = field_w(maxy);

   logic [NPORTS-1:0] in_req, out_ack;
   logic [n-1:0]      in_data [NPORTS];

   logic [NPORTS-1:0] req_s1_q, req_s2_q, in_ack_q, full_q;
   logic [NPORTS-1:0] ack_s1_q, ack_s2_q, out_req_q;
   logic [n-1:0]      slot_q     [NPORTS];
   logic [n-1:0]      out_data_q [NPORTS];

   route_e            route_c [NPORTS];
   logic [NPORTS-1:0] arb_req_c [NPORTS];
   logic [NPORTS-1:0] gnt_c     [NPORTS];
   logic [n-1:0]      sel_c     [NPORTS];
   logic [NPORTS-1:0] launch_c, freed_c;

   assign in_req[0] = proc_input.req;   assign in_data[0] = proc_input.data;
   assign in_req[1] = port1_input.req;  assign in_data[1] = port1_input.data;
   assign in_req[2] = port2_input.req;  assign in_data[2] = port2_input.data;
   assign in_req[3] = port3_input.req;  assign in_data[3] = port3_input.data;
   assign proc_input.ack  = in_ack_q[0];
   assign port1_input.ack = in_ack_q[1];
   assign port2_input.ack = in_ack_q[2];
   assign port3_input.ack = in_ack_q[3];

   assign proc_output.req  = out_req_q[0];  assign proc_output.data  = out_data_q[0];
   assign port1_output.req = out_req_q[1];  assign port1_output.data = out_data_q[1];
   assign port2_output.req = out_req_q[2];  assign port2_output.data = out_data_q[2];
   assign port3_output.req = out_req_q[3];  assign port3_output.data = out_data_q[3];
   assign out_ack[0] = proc_output.ack;
   assign out_ack[1] = port1_output.ack;
   assign out_ack[2] = port2_output.ack;
   assign out_ack[3] = port3_output.ack;

   // Route decode straight from the buffered header
   for (genvar i = 0; i < NPORTS; i++) begin : g_route
      logic dx, dy;
      assign dx         = slot_q[i][n-1 -: XW] != XW'(srcx);
      assign dy         = slot_q[i][n-1-XW -: YW] != YW'(srcy);
      assign route_c[i] = route_of(rtype, dx, dy);
   end

   always_comb begin
      for (int unsigned j = 0; j < NPORTS; j++) begin
         for (int unsigned i = 0; i < NPORTS; i++)
            arb_req_c[j][i] = full_q[i] && (route_c[i] == route_e'(2'(j)));
         launch_c[j] = (ack_s2_q[j] == out_req_q[j]) && (|arb_req_c[j]);
      end
   end

   for (genvar j = 0; j < NPORTS; j++) begin : g_arb
      rr_arbiter4 u_arb (
         .clk     (clk),
         .rst     (rst),
         .req_i   (arb_req_c[j]),
         .en_i    (launch_c[j]),
         .gnt_c_o (gnt_c[j])
      );
   end

   always_comb begin
      freed_c = '0;
      for (int unsigned j = 0; j < NPORTS; j++) begin
         sel_c[j] = '0;
         for (int unsigned i = 0; i < NPORTS; i++)
            if (gnt_c[j][i]) sel_c[j] = slot_q[i];
         if (launch_c[j]) freed_c = freed_c | gnt_c[j];
      end
   end

   // A full slot can only free; an empty slot can only capture
   always_ff @(posedge clk) begin
      if (rst) begin
         req_s1_q  <= '0;
         req_s2_q  <= '0;
         in_ack_q  <= '0;
         full_q    <= '0;
         ack_s1_q  <= '0;
         ack_s2_q  <= '0;
         out_req_q <= '0;
         for (int unsigned i = 0; i < NPORTS; i++) begin
            slot_q[i]     <= '0;
            out_data_q[i] <= '0;
         end
      end else begin
         req_s1_q <= in_req;
         req_s2_q <= req_s1_q;
         ack_s1_q <= out_ack;
         ack_s2_q <= ack_s1_q;
         for (int unsigned i = 0; i < NPORTS; i++) begin
            if (freed_c[i]) begin
               full_q[i] <= 1'b0;
            end else if (!full_q[i] && (req_s2_q[i] != in_ack_q[i])) begin
               slot_q[i]   <= in_data[i];
               in_ack_q[i] <= ~in_ack_q[i];
               full_q[i]   <= 1'b1;
            end
         end
         for (int unsigned j = 0; j < NPORTS; j++) begin
            if (launch_c[j]) begin
               out_data_q[j] <= sel_c[j];
               out_req_q[j]  <= ~out_req_q[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_dally_corner_router.sv
// Directed bench for dally_corner_router: routing, latency, ordering, round-robin,
// back-pressure and mid-transfer reset.
module tb_dally_corner_router;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  s_req = '0;
   logic [31:0] s_data [4];
   logic [3:0]  hold = '0;
   wire  [3:0]  i_ack_w, o_req_w, o_ack_w;
   wire  [31:0] o_data_w [4];
   int          total = 0;
   int          bad = 0;
   int          ack0_cnt = 0;

   always #10 clk = ~clk;

   RTPort #(.N(32)) pi0(), pi1(), pi2(), pi3();
   RTPort #(.N(32)) po0(), po1(), po2(), po3();

   assign pi0.req = s_req[0];  assign pi0.data = s_data[0];  assign i_ack_w[0] = pi0.ack;
   assign pi1.req = s_req[1];  assign pi1.data = s_data[1];  assign i_ack_w[1] = pi1.ack;
   assign pi2.req = s_req[2];  assign pi2.data = s_data[2];  assign i_ack_w[2] = pi2.ack;
   assign pi3.req = s_req[3];  assign pi3.data = s_data[3];  assign i_ack_w[3] = pi3.ack;
   assign o_req_w[0] = po0.req;  assign o_data_w[0] = po0.data;  assign po0.ack = o_ack_w[0];
   assign o_req_w[1] = po1.req;  assign o_data_w[1] = po1.data;  assign po1.ack = o_ack_w[1];
   assign o_req_w[2] = po2.req;  assign o_data_w[2] = po2.data;  assign po2.ack = o_ack_w[2];
   assign o_req_w[3] = po3.req;  assign o_data_w[3] = po3.data;  assign po3.ack = o_ack_w[3];

   dally_corner_router #(
      .rtype (router_pkg::CORNERSW),
      .n     (32),
      .srcx  (0),
      .srcy  (0),
      .maxx  (1),
      .maxy  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .proc_input   (pi0),
      .proc_output  (po0),
      .port1_input  (pi1),
      .port1_output (po1),
      .port2_input  (pi2),
      .port2_output (po2),
      .port3_input  (pi3),
      .port3_output (po3)
   );

   // Sinks: log every req edge, answer with ack 10 time units later unless held
   for (genvar g = 0; g < 4; g++) begin : g_sink
      int          cnt = 0;
      logic [31:0] hist [16];
      logic        ack_v = 1'b0;
      assign o_ack_w[g] = ack_v;
      initial forever begin
         @(o_req_w[g]);
         #1;
         hist[cnt % 16] = o_data_w[g];
         cnt++;
         #9;
         wait (!hold[g]);
         ack_v = o_req_w[g];
      end
   end

   initial forever begin
      @(i_ack_w[0]);
      ack0_cnt++;
   end

   function automatic int get_cnt(input int g);
      case (g)
         0:       return g_sink[0].cnt;
         1:       return g_sink[1].cnt;
         2:       return g_sink[2].cnt;
         default: return g_sink[3].cnt;
      endcase
   endfunction

   function automatic logic [31:0] get_hist(input int g, input int k);
      case (g)
         0:       return g_sink[0].hist[k % 16];
         1:       return g_sink[1].hist[k % 16];
         2:       return g_sink[2].hist[k % 16];
         default: return g_sink[3].hist[k % 16];
      endcase
   endfunction

   function automatic int sum_cnt();
      return get_cnt(0) + get_cnt(1) + get_cnt(2) + get_cnt(3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send(input int p, input logic [31:0] d);
      s_data[p] = d;
      s_req[p]  = ~s_req[p];
   endtask

   task automatic wait_ack(input int p, input string tag);
      for (int k = 0; k < 20 && i_ack_w[p] !== s_req[p]; k++) @(negedge clk);
      chk(tag, 32'(i_ack_w[p]), 32'(s_req[p]));
   endtask

   task automatic deliver(input int p, input logic [31:0] d, input int g, input string tag);
      int b, tot;
      b   = get_cnt(g);
      tot = sum_cnt();
      send(p, d);
      for (int k = 0; k < 20 && get_cnt(g) == b; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({tag, "_cnt"}, 32'(get_cnt(g) - b), 32'd1);
      chk({tag, "_data"}, get_hist(g, b), d);
      chk({tag, "_only"}, 32'(sum_cnt() - tot), 32'd1);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      s_req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int b, a0, tot;
      for (int k = 0; k < 4; k++) s_data[k] = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_req", 32'(o_req_w), 32'd0);
      chk("rst_in_ack", 32'(i_ack_w), 32'd0);
      for (int k = 0; k < 4; k++) chk("rst_out_data", o_data_w[k], 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Y-differs flit: proc -> port2, four-clock latency
      b  = get_cnt(2);
      a0 = ack0_cnt;
      send(0, 32'h5FFF_FFFF);
      repeat (3) @(negedge clk);
      chk("lat_3clk_no_req", 32'(o_req_w[2]), 32'd0);
      @(negedge clk);
      chk("lat_4clk_req", 32'(o_req_w[2]), 32'd1);
      chk("p2_data", o_data_w[2], 32'h5FFF_FFFF);
      repeat (6) @(negedge clk);
      chk("p2_req_once", 32'(get_cnt(2) - b), 32'd1);
      chk("proc_ack_once", 32'(ack0_cnt - a0), 32'd1);

      deliver(0, 32'hAFFF_FFFF, 1, "proc_to_p1");
      deliver(0, 32'hFFFF_FFFF, 3, "proc_to_p3");
      deliver(0, 32'h0FFF_FFFF, 0, "proc_loop");

      // Two back-to-back flits on port1 come out of proc_output in order
      b = get_cnt(0);
      send(1, 32'h2EEE_EEEE);
      wait_ack(1, "p1_ack_first");
      send(1, 32'h2AAA_AAAA);
      wait_ack(1, "p1_ack_second");
      for (int k = 0; k < 40 && get_cnt(0) < b + 2; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("p1_pair_cnt", 32'(get_cnt(0) - b), 32'd2);
      chk("p1_pair_first", get_hist(0, b), 32'h2EEE_EEEE);
      chk("p1_pair_second", get_hist(0, b + 1), 32'h2AAA_AAAA);

      // Simultaneous port1/port2 contention from a fresh pointer
      do_reset();
      b = get_cnt(0);
      s_data[1] = 32'h2AAA_AAAA;
      s_data[2] = 32'h1DDD_DDDD;
      s_req[1]  = ~s_req[1];
      s_req[2]  = ~s_req[2];
      for (int k = 0; k < 20 && get_cnt(0) == b; k++) @(negedge clk);
      chk("rr_first", get_hist(0, b), 32'h2AAA_AAAA);
      repeat (2) @(negedge clk);
      chk("rr_wait_for_ack", 32'(get_cnt(0) - b), 32'd1);
      @(negedge clk);
      chk("rr_second_cnt", 32'(get_cnt(0) - b), 32'd2);
      chk("rr_second", get_hist(0, b + 1), 32'h1DDD_DDDD);

      // Back-pressure: port2 ack withheld, three flits from proc
      hold[2] = 1'b1;
      b  = get_cnt(2);
      a0 = ack0_cnt;
      send(0, 32'h5FFF_FFFF);
      wait_ack(0, "bp_ack1");
      send(0, 32'h5FFF_FFFF);
      wait_ack(0, "bp_ack2");
      send(0, 32'h5FFF_FFFF);
      repeat (15) @(negedge clk);
      chk("bp_out_once", 32'(get_cnt(2) - b), 32'd1);
      chk("bp_ack_twice", 32'(ack0_cnt - a0), 32'd2);
      chk("bp_held_data", o_data_w[2], 32'h5FFF_FFFF);
      hold[2] = 1'b0;
      for (int k = 0; k < 80 && get_cnt(2) < b + 3; k++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("bp_out_three", 32'(get_cnt(2) - b), 32'd3);
      chk("bp_ack_three", 32'(ack0_cnt - a0), 32'd3);

      // Reset with one flit on port1 output and one buffered behind it
      hold[1] = 1'b1;
      send(0, 32'hAFFF_FFFF);
      wait_ack(0, "rm_ack1");
      send(0, 32'hAFFF_FFFF);
      wait_ack(0, "rm_ack2");
      repeat (4) @(negedge clk);
      chk("rm_pre_req", 32'(o_req_w[1]), 32'd1);
      rst   = 1'b1;
      s_req = '0;
      @(negedge clk);
      chk("rm_out_req", 32'(o_req_w), 32'd0);
      chk("rm_in_ack", 32'(i_ack_w), 32'd0);
      for (int k = 0; k < 4; k++) chk("rm_out_data", o_data_w[k], 32'd0);
      hold = '0;
      rst  = 1'b0;
      repeat (3) @(negedge clk);
      tot = sum_cnt();
      repeat (20) @(negedge clk);
      chk("rm_no_emit", 32'(sum_cnt() - tot), 32'd0);
      chk("rm_idle_req", 32'(o_req_w), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
